// File: rtl/booth_multiplier_if.sv
// booth_multiplier_if
//   Start/ready handshake and operand/result bus of the Booth multiplier,
//   matching the divider's handshake in the multdiv unit.
//
//   ctrl_MULT       master -> slave   start pulse
//   data_operandA   master -> slave   multiplicand (two's complement)
//   data_operandB   master -> slave   multiplier (two's complement)
//   data_result     slave  -> master  low WIDTH bits of A*B
//   data_exception  slave  -> master  signed overflow of data_result
//   data_resultRDY  slave  -> master  one-cycle completion strobe
interface booth_multiplier_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output ctrl_MULT,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_exception,
        input  data_resultRDY
    );

    modport slave (
        input  ctrl_MULT,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_exception,
        output data_resultRDY
    );
endinterface

// File: rtl/booth_multiplier.sv
// booth_multiplier
//   Sequential signed WIDTH x WIDTH radix-2 Booth multiplier. One add/sub
//   and one arithmetic right shift per cycle, WIDTH iterations. Returns the
//   low WIDTH bits of the product and flags signed overflow.
//
//   clock  system clock, rising edge
//   reset  synchronous, active-low; clears all state
//   bus    booth_multiplier_if.slave (start, operands, result, exception, ready)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for ctrl_MULT
//   S_RUN  | iterating Booth steps; ctrl_MULT here aborts and restarts
//   S_DONE | data_resultRDY high for this cycle; accepts a new start
module booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                clock,
    input  logic                reset,
    booth_multiplier_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               load;
    logic               step;
    logic               finish;

    logic [WIDTH-1:0]   m_reg;
    logic [2*WIDTH:0]   p_reg;
    logic [CW-1:0]      counter;
    logic [WIDTH-1:0]   result_q;
    logic               exception_q;
    logic               rdy_q;

    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               q_1;
    logic [WIDTH:0]     hi_ext;
    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   p_step;
    logic               overflow;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.ctrl_MULT) begin
                    load       = 1'b1;
                    state_next = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (bus.ctrl_MULT) begin
                    load = 1'b1;
                end else begin
                    step = 1'b1;
                    if (counter == CW'(WIDTH - 1)) begin
                        finish     = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Booth step. The add/sub is done one bit wider than the operands so the
    // bit shifted into the top is the true sign of the sum, which keeps a
    // 0x80000000 multiplicand correct even when the WIDTH-bit sum wraps.
    always_comb begin
        hi     = p_reg[2*WIDTH:WIDTH+1];
        lo     = p_reg[WIDTH:1];
        q_1    = p_reg[0];
        hi_ext = {hi[WIDTH-1], hi};
        m_ext  = {m_reg[WIDTH-1], m_reg};
        case ({lo[0], q_1})
            2'b01:   sum = hi_ext + m_ext;
            2'b10:   sum = hi_ext - m_ext;
            default: sum = hi_ext;
        endcase
        p_step = {sum[WIDTH], sum[WIDTH-1:0], lo};
        // Product is p_step[2W:1]; its upper WIDTH+1 bits must be a pure
        // sign extension of the low word for the result to be exact.
        overflow = !((&p_step[2*WIDTH:WIDTH]) || (~|p_step[2*WIDTH:WIDTH]));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            m_reg       <= '0;
            p_reg       <= '0;
            counter     <= '0;
            result_q    <= '0;
            exception_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            rdy_q <= finish;
            if (load) begin
                m_reg   <= bus.data_operandA;
                p_reg   <= {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
                counter <= '0;
            end else if (step) begin
                p_reg   <= p_step;
                counter <= counter + CW'(1);
                if (finish) begin
                    result_q    <= p_step[WIDTH:1];
                    exception_q <= overflow;
                end
            end
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exception_q;
    assign bus.data_resultRDY = rdy_q;
endmodule

// File: tb/tb_booth_multiplier.sv
module tb_booth_multiplier;
    localparam int WIDTH = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    booth_multiplier_if #(.WIDTH(WIDTH)) bif ();

    booth_multiplier #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Drives a one-cycle start; returns #1 after the start edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bif.data_operandA = a;
        bif.data_operandB = b;
        bif.ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        bif.ctrl_MULT = 1'b0;
    endtask

    // Counts edges until RDY is seen; -1 if not seen within the budget.
    task automatic wait_rdy(output int edges);
        edges = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock);
            #1;
            if (bif.data_resultRDY) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        vectors++;
        if (bif.data_result !== 32'h0) begin
            $display("FAIL reset_result got=%h exp=%h", bif.data_result, 32'h0);
            miscompares++;
        end
        vectors++;
        if (bif.data_exception !== 1'b0) begin
            $display("FAIL reset_exception got=%b exp=0", bif.data_exception);
            miscompares++;
        end
        vectors++;
        if (bif.data_resultRDY !== 1'b0) begin
            $display("FAIL reset_rdy got=%b exp=0", bif.data_resultRDY);
            miscompares++;
        end
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clock);
                #1;
                if (bif.data_resultRDY !== 1'b0) seen++;
            end
            vectors++;
            if (seen != 0) begin
                $display("FAIL idle_no_rdy got=%0d rdy cycles exp=0", seen);
                miscompares++;
            end
        end
    endtask

    task automatic test_basic();
        int e;
        start_op(32'd3, 32'd5);
        bif.data_operandA = 32'hDEADBEEF;
        bif.data_operandB = 32'h12345678;
        wait_rdy(e);
        vectors++;
        if (e != 32) begin
            $display("FAIL basic_latency got=%0d exp=32", e);
            miscompares++;
        end
        vectors++;
        if (bif.data_result !== 32'h0000000F) begin
            $display("FAIL basic_result got=%h exp=%h", bif.data_result, 32'h0000000F);
            miscompares++;
        end
        vectors++;
        if (bif.data_exception !== 1'b0) begin
            $display("FAIL basic_exception got=%b exp=0", bif.data_exception);
            miscompares++;
        end
        @(posedge clock);
        #1;
        vectors++;
        if (bif.data_resultRDY !== 1'b0) begin
            $display("FAIL basic_rdy_width got=%b exp=0", bif.data_resultRDY);
            miscompares++;
        end
        vectors++;
        if (bif.data_result !== 32'h0000000F) begin
            $display("FAIL basic_hold got=%h exp=%h", bif.data_result, 32'h0000000F);
            miscompares++;
        end
    endtask

    // Signed products, each started in the DONE cycle of the previous one.
    task automatic test_back_to_back();
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic [31:0] tr [4];
        logic        tx [4];
        int e;
        ta[0] = 32'hFFFFFFF9; tb[0] = 32'd6;        tr[0] = 32'hFFFFFFD6; tx[0] = 1'b0;
        ta[1] = 32'h80000000; tb[1] = 32'd1;        tr[1] = 32'h80000000; tx[1] = 1'b0;
        ta[2] = 32'hFFFFFFFF; tb[2] = 32'hFFFFFFFF; tr[2] = 32'h00000001; tx[2] = 1'b0;
        ta[3] = 32'hFFFFFFFD; tb[3] = 32'h80000001; tr[3] = 32'h7FFFFFFD; tx[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_op(ta[i], tb[i]);
            wait_rdy(e);
            vectors++;
            if (e != 32) begin
                $display("FAIL b2b_latency[%0d] got=%0d exp=32", i, e);
                miscompares++;
            end
            vectors++;
            if (bif.data_result !== tr[i]) begin
                $display("FAIL b2b_result[%0d] got=%h exp=%h", i, bif.data_result, tr[i]);
                miscompares++;
            end
            vectors++;
            if (bif.data_exception !== tx[i]) begin
                $display("FAIL b2b_exception[%0d] got=%b exp=%b", i, bif.data_exception, tx[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] ta [5];
        logic [31:0] tb [5];
        logic [31:0] tr [5];
        logic        tx [5];
        int e;
        ta[0] = 32'h7FFFFFFF; tb[0] = 32'd2;        tr[0] = 32'hFFFFFFFE; tx[0] = 1'b1;
        ta[1] = 32'h80000000; tb[1] = 32'hFFFFFFFF; tr[1] = 32'h80000000; tx[1] = 1'b1;
        ta[2] = 32'h00010000; tb[2] = 32'h00008000; tr[2] = 32'h80000000; tx[2] = 1'b1;
        ta[3] = 32'h80000000; tb[3] = 32'h80000000; tr[3] = 32'h00000000; tx[3] = 1'b1;
        ta[4] = 32'h12345678; tb[4] = 32'h00000000; tr[4] = 32'h00000000; tx[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start_op(ta[i], tb[i]);
            wait_rdy(e);
            vectors++;
            if (e != 32) begin
                $display("FAIL ovf_latency[%0d] got=%0d exp=32", i, e);
                miscompares++;
            end
            vectors++;
            if (bif.data_result !== tr[i]) begin
                $display("FAIL ovf_result[%0d] got=%h exp=%h", i, bif.data_result, tr[i]);
                miscompares++;
            end
            vectors++;
            if (bif.data_exception !== tx[i]) begin
                $display("FAIL ovf_exception[%0d] got=%b exp=%b", i, bif.data_exception, tx[i]);
                miscompares++;
            end
        end
    endtask

    // Previous completion left result=0, exception=0.
    task automatic test_restart();
        int e;
        int seen;
        seen = 0;
        start_op(32'd2, 32'd2);
        for (int i = 0; i < 9; i++) begin
            @(posedge clock);
            #1;
            if (bif.data_resultRDY !== 1'b0) seen++;
        end
        start_op(32'd4, 32'd4);
        vectors++;
        if (bif.data_result !== 32'h0) begin
            $display("FAIL restart_hold got=%h exp=%h", bif.data_result, 32'h0);
            miscompares++;
        end
        wait_rdy(e);
        vectors++;
        if (e != 32) begin
            $display("FAIL restart_latency got=%0d exp=32", e);
            miscompares++;
        end
        vectors++;
        if (bif.data_result !== 32'd16) begin
            $display("FAIL restart_result got=%h exp=%h", bif.data_result, 32'd16);
            miscompares++;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            if (bif.data_resultRDY !== 1'b0) seen++;
        end
        vectors++;
        if (seen != 0) begin
            $display("FAIL restart_extra_rdy got=%0d rdy cycles exp=0", seen);
            miscompares++;
        end
    endtask

    task automatic test_held_start();
        int seen;
        seen = 0;
        @(negedge clock);
        bif.data_operandA = 32'd7;
        bif.data_operandB = 32'd7;
        bif.ctrl_MULT     = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (bif.data_resultRDY !== 1'b0) seen++;
        end
        bif.ctrl_MULT = 1'b0;
        vectors++;
        if (seen != 0) begin
            $display("FAIL held_start_rdy got=%0d rdy cycles exp=0", seen);
            miscompares++;
        end
        vectors++;
        if (bif.data_result !== 32'd16) begin
            $display("FAIL held_start_hold got=%h exp=%h", bif.data_result, 32'd16);
            miscompares++;
        end
    endtask

    task automatic test_reset_midop();
        int e;
        int seen;
        seen = 0;
        start_op(32'd9, 32'd9);
        repeat (19) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        vectors++;
        if (bif.data_result !== 32'h0) begin
            $display("FAIL midreset_result got=%h exp=%h", bif.data_result, 32'h0);
            miscompares++;
        end
        vectors++;
        if (bif.data_exception !== 1'b0 || bif.data_resultRDY !== 1'b0) begin
            $display("FAIL midreset_flags got=%b%b exp=00", bif.data_exception, bif.data_resultRDY);
            miscompares++;
        end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (bif.data_resultRDY !== 1'b0) seen++;
        end
        vectors++;
        if (seen != 0) begin
            $display("FAIL midreset_rdy got=%0d rdy cycles exp=0", seen);
            miscompares++;
        end
        start_op(32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_rdy(e);
        vectors++;
        if (e != 32) begin
            $display("FAIL post_reset_latency got=%0d exp=32", e);
            miscompares++;
        end
        vectors++;
        if (bif.data_result !== 32'd1 || bif.data_exception !== 1'b0) begin
            $display("FAIL post_reset_result got=%h/%b exp=%h/0", bif.data_result, bif.data_exception, 32'd1);
            miscompares++;
        end
    endtask

    initial begin
        bif.ctrl_MULT     = 1'b0;
        bif.data_operandA = '0;
        bif.data_operandB = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_restart();
        test_held_start();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
